inv_byte_substitution_engine: RTL
=================================

Name: inv_byte_substitution_engine

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse of the forward byte S-box.
- Accepts a full state word over a valid/ready handshake.
- Processes one byte at a time: inverse affine transform, then multiplicative inversion in GF(2^8) (polynomial 0x11B) computed as x^254 by square-and-multiply.
- Returns the substituted state word over a second valid/ready handshake.
- Contains no 256-entry table; trades latency for area.

Parameters:
NUM_BYTES, 16, number of bytes in the state word (16 gives a 128-bit AES state); must be >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_state is valid
in_ready  output  1  engine idle and able to accept in_state
in_state  input  8*NUM_BYTES  ciphertext-side state; byte i = in_state[8*(NUM_BYTES-i)-1 -: 8] (byte 0 = MSB)
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts out_state
out_state  output  8*NUM_BYTES  InvSubBytes(in_state), same byte ordering
busy  output  1  high in LOAD or ITER

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge), including mid-operation:
  - state=IDLE; out_valid=0, busy=0, out_state=0, byte counter=0, iteration counter=0.
  - Any in-progress operation is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, LOAD, ITER, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_state into the working register, byte_idx=0, go to LOAD.
  - LOAD (1 cycle): take s = working byte[byte_idx].
    - Inverse affine: a = rotl(s,1) ^ rotl(s,3) ^ rotl(s,6) ^ 8'h05.
    - Set sq=a, acc=8'h01, k=1; go to ITER.
  - ITER (7 cycles, k=1..7), each cycle: sq_next = sq*sq; acc_next = acc*sq_next; both are GF(2^8) multiplies, combinational within the cycle.
    - After k=7, acc = a^254 = a^-1, with 0 mapping to 0 and no special case.
    - On k=7, write acc into result byte[byte_idx].
    - If byte_idx==NUM_BYTES-1, go to DONE; else byte_idx++ and go to LOAD.
  - DONE: out_valid=1 and out_state stable. On out_ready go to IDLE. out_valid drops the cycle after the handshake; out_state holds its value until the next result is written.
- in_ready is 1 only in IDLE. The input is ignored in every other state, and in_state may change freely after acceptance.
- Latency:
  - Input handshake at edge T: LOAD of byte 0 occupies cycle T+1; each byte takes 8 cycles.
  - out_valid first high in cycle T+1+8*NUM_BYTES (T+129 for NUM_BYTES=16).
  - Throughput: one state per 8*NUM_BYTES+2 cycles minimum, with out_ready tied high.
- Back-pressure: DONE holds indefinitely while out_ready=0; no new input is accepted.
- out_valid is never asserted without a preceding accepted input since reset.
- Counters:
  - byte_idx width is clog2(NUM_BYTES), minimum 1; it never wraps past NUM_BYTES-1.
  - k is a 3-bit counter.
- Simultaneous events:
  - in_valid is ignored in DONE, even when out_ready=1 in the same cycle.
  - rst has priority over every handshake.

Test Plan:
1. Reset then in_state=128'h637C777BF26B6FC53001672BFED7AB76 -> out_state=128'h000102030405060708090A0B0C0D0E0F, out_valid first high exactly 129 cycles after the accept edge.
2. in_state all bytes 8'h63 -> all bytes 8'h00 (zero-inverse path); in_state all 8'h00 -> all 8'h52; all 8'h16 -> all 8'hFF.
3. Mixed vector 128'hED52_7C16_0000_0000_0000_0000_0000_0000 -> 128'h5348_01FF_5252_...52. Checks byte ordering: byte 0 lands in bits [127:120].
4. Hold out_ready=0 for 50 cycles after out_valid -> out_valid and out_state stable, in_ready=0, new in_valid ignored; then out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
5. Assert rst at cycle 40 of an operation -> next cycle out_valid=0, out_state=0, in_ready=1. A new input then completes in 129 cycles with the correct result.
6. Random regression, 1000 states against a software inverse S-box with random in_valid/out_ready gaps -> all results match, and there is exactly one out handshake per accepted input.

Source files
------------

// File: rtl/inv_byte_substitution_engine.sv
// Iterative AES InvSubBytes: per byte, inverse affine then GF(2^8) inversion as a^254.
// Two GF multiplies per cycle; one byte per 8 cycles, no lookup table.
module inv_byte_substitution_engine #(
  parameter int NUM_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NUM_BYTES-1:0]   in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NUM_BYTES-1:0]   out_state,
  output logic                     busy
);

  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [8*NUM_BYTES-1:0] r_work, r_result, w_result_next;
  logic [BW-1:0]          r_byte_idx;
  logic [2:0]             r_k;
  logic [7:0]             r_sq, r_acc;
  logic [7:0]             w_sq_next, w_acc_next, w_s, w_a;
  logic [7:0]             w_work_bytes [NUM_BYTES];
  logic                   w_accept, w_write;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_write  = (r_state == S_ITER) && (r_k == 3'd7);

  // Byte 0 sits in the most significant position of both state words
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign w_work_bytes[gi] = r_work[8*(NUM_BYTES-gi)-1 -: 8];
      assign w_result_next[8*(NUM_BYTES-gi)-1 -: 8] =
        (w_write && (r_byte_idx == BW'(gi))) ? w_acc_next
                                             : r_result[8*(NUM_BYTES-gi)-1 -: 8];
    end
  endgenerate

  assign w_s = w_work_bytes[r_byte_idx];
  assign w_a = {w_s[6:0], w_s[7]} ^ {w_s[4:0], w_s[7:5]} ^ {w_s[1:0], w_s[7:2]} ^ 8'h05;

  // After seven steps sq = a^128 and acc = a^(2+4+...+128) = a^254
  assign w_sq_next  = gf_mul(r_sq, r_sq);
  assign w_acc_next = gf_mul(r_acc, w_sq_next);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        busy         = 1'b1;
        w_state_next = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_k == 3'd7) w_state_next = (r_byte_idx == LAST_IDX) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work     <= '0;
      r_result   <= '0;
      r_byte_idx <= '0;
      r_k        <= 3'd0;
      r_sq       <= 8'h00;
      r_acc      <= 8'h00;
    end else begin
      r_result <= w_result_next;
      if (w_accept) begin
        r_work     <= in_state;
        r_byte_idx <= '0;
      end
      case (r_state)
        S_LOAD: begin
          r_sq  <= w_a;
          r_acc <= 8'h01;
          r_k   <= 3'd1;
        end
        S_ITER: begin
          r_sq  <= w_sq_next;
          r_acc <= w_acc_next;
          r_k   <= r_k + 3'd1;
          if ((r_k == 3'd7) && (r_byte_idx != LAST_IDX)) r_byte_idx <= r_byte_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_state = r_result;

endmodule
